// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// active-low segment codes, bit positions and the scan state type.
package seg7_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Element [n] is the code for hex value n (dp bit off).
    localparam logic [15:0][7:0] SEG_CODES = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Input controls and display drive of the scan controller; master drives
// the controls, slave (the controller) drives the display pins.
interface seg7_scan_ctrl_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                  enable;
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp_en;
    logic [N_DIGITS-1:0]   blink_en;
    logic                  blank_lz;
    logic [N_DIGITS-1:0]   DIGIT;
    logic [7:0]            DISPLAY;
    logic                  frame_tick;

    modport master (
        output enable, digits, dp_en, blink_en, blank_lz,
        input  DIGIT, DISPLAY, frame_tick
    );

    modport slave (
        input  enable, digits, dp_en, blink_en, blank_lz,
        output DIGIT, DISPLAY, frame_tick
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low a..g segment decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_CODES[nibble_i][SEG_G:SEG_A];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-frame input snapshot,
// leading-zero blanking, per-digit decimal point and blink.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);
    localparam int unsigned SLOT_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
    localparam int unsigned FRM_W   = $clog2(BLINK_FRAMES + 1);
    localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(N_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0]   FRM_MAX   = FRM_W'(BLINK_FRAMES);

    scan_state_e           state_q, state_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [FRM_W-1:0]      frm_cnt_q, frm_cnt_d;
    logic                  blink_on_q, blink_on_d;
    logic [4*N_DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic                  snap_blz_q, snap_blz_d;
    logic [N_DIGITS-1:0]   digit_q, digit_d;
    logic [7:0]            display_q, display_d;
    logic                  ftick_q, ftick_d;

    logic                  scan_tick, frame_start;
    logic [3:0]            sel_nib;
    logic                  sel_dp, sel_blink, lz_all;
    logic [N_DIGITS-1:0]   sel_onehot;
    logic [6:0]            seg;

    // Scan sequencing, snapshot capture and blink phase.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        slot_d       = slot_q;
        frm_cnt_d    = frm_cnt_q;
        blink_on_d   = blink_on_q;
        snap_dig_d   = snap_dig_q;
        snap_dp_d    = snap_dp_q;
        snap_blink_d = snap_blink_q;
        snap_blz_d   = snap_blz_q;
        scan_tick    = 1'b0;
        frame_start  = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            presc_d = '0;
            slot_d  = '0;
        end else begin
            if (presc_q == PRESC_MAX) begin
                presc_d   = '0;
                scan_tick = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            if (scan_tick) begin
                state_d = ST_SCAN;
                unique case (state_q)
                    ST_IDLE: slot_d = '0;
                    ST_SCAN: slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
                    default: slot_d = '0;
                endcase
                frame_start = (slot_d == '0);
            end
            if (frame_start) begin
                snap_dig_d   = bus.digits;
                snap_dp_d    = bus.dp_en;
                snap_blink_d = bus.blink_en;
                snap_blz_d   = bus.blank_lz;
                // Counter holds frames already shown in this phase, so the
                // toggle lands on the first frame of the next half-period.
                if (frm_cnt_q == FRM_MAX) begin
                    blink_on_d = ~blink_on_q;
                    frm_cnt_d  = FRM_W'(1);
                end else begin
                    frm_cnt_d = frm_cnt_q + 1'b1;
                end
            end
        end
    end

    // Per-slot selection from the snapshot that will be live after this edge.
    always_comb begin
        sel_nib    = '0;
        sel_dp     = 1'b0;
        sel_blink  = 1'b0;
        lz_all     = 1'b1;
        sel_onehot = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (SLOT_W'(i) == slot_d) begin
                sel_nib       = snap_dig_d[4*i +: 4];
                sel_dp        = snap_dp_d[i];
                sel_blink     = snap_blink_d[i];
                sel_onehot[i] = 1'b1;
            end
            if (SLOT_W'(i) >= slot_d && snap_dig_d[4*i +: 4] != 4'h0) begin
                lz_all = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .nibble_i (sel_nib),
        .seg_o    (seg)
    );

    always_comb begin
        digit_d   = digit_q;
        display_d = display_q;
        ftick_d   = 1'b0;
        if (!bus.enable) begin
            digit_d   = '1;
            display_d = SEG_BLANK;
        end else if (scan_tick) begin
            digit_d = ~sel_onehot;
            ftick_d = frame_start;
            if ((snap_blz_d && slot_d != '0 && lz_all) || (!blink_on_d && sel_blink)) begin
                display_d = SEG_BLANK;
            end else begin
                display_d[SEG_DP]      = ~sel_dp;
                display_d[SEG_G:SEG_A] = seg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            slot_q       <= '0;
            frm_cnt_q    <= '0;
            blink_on_q   <= 1'b1;
            snap_dig_q   <= '0;
            snap_dp_q    <= '0;
            snap_blink_q <= '0;
            snap_blz_q   <= 1'b0;
            digit_q      <= '1;
            display_q    <= SEG_BLANK;
            ftick_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            frm_cnt_q    <= frm_cnt_d;
            blink_on_q   <= blink_on_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            snap_blink_q <= snap_blink_d;
            snap_blz_q   <= snap_blz_d;
            digit_q      <= digit_d;
            display_q    <= display_d;
            ftick_q      <= ftick_d;
        end
    end

    assign bus.DIGIT      = digit_q;
    assign bus.DISPLAY    = display_q;
    assign bus.frame_tick = ftick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4-digit instance (SCAN_DIV=4,
// BLINK_FRAMES=2) plus a 1-digit instance (SCAN_DIV=2, BLINK_FRAMES=1).
module tb_seg7_scan_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    seg7_scan_ctrl_if #(.N_DIGITS(4)) bus4 ();
    seg7_scan_ctrl_if #(.N_DIGITS(1)) bus1 ();

    seg7_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    seg7_scan_ctrl #(.N_DIGITS(1), .SCAN_DIV(2), .BLINK_FRAMES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] sel4  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set4(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                        input logic blz);
        bus4.digits   = d;
        bus4.dp_en    = dp;
        bus4.blink_en = bl;
        bus4.blank_lz = blz;
    endtask

    task automatic test_reset();
        set4(16'h1234, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus4.DIGIT !== 4'hF || bus4.DISPLAY !== 8'hFF || bus4.frame_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: DIGIT=%h DISPLAY=%h tick=%b, want F FF 0",
                     bus4.DIGIT, bus4.DISPLAY, bus4.frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        tests_run++;
        if (bus4.DIGIT !== 4'hF) begin
            tests_failed++;
            $display("FAIL dark_before_tick: DIGIT=%h, want F", bus4.DIGIT);
        end
        step(1);
        tests_run++;
        if (bus4.DIGIT !== 4'hE || bus4.DISPLAY !== 8'h99 || bus4.frame_tick !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_slot: DIGIT=%h DISPLAY=%h tick=%b, want E 99 1",
                     bus4.DIGIT, bus4.DISPLAY, bus4.frame_tick);
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp_disp [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        set4(16'h1234, 4'h0, 4'h0, 1'b0);
        do_reset();
        step(4);
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) begin
                tests_run++;
                if (bus4.DIGIT !== sel4[s] || bus4.DISPLAY !== exp_disp[s] ||
                    bus4.frame_tick !== (s == 0)) begin
                    tests_failed++;
                    $display("FAIL scan f%0d s%0d: DIGIT=%h DISPLAY=%h tick=%b, want %h %h %b",
                             f, s, bus4.DIGIT, bus4.DISPLAY, bus4.frame_tick,
                             sel4[s], exp_disp[s], (s == 0));
                end
                step(1);
                tests_run++;
                if (bus4.DIGIT !== sel4[s] || bus4.frame_tick !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL hold f%0d s%0d: DIGIT=%h tick=%b, want %h 0",
                             f, s, bus4.DIGIT, bus4.frame_tick, sel4[s]);
                end
                step(3);
            end
        end
    endtask

    task automatic test_codes();
        for (int g = 0; g < 4; g++) begin
            set4({4'(4*g+3), 4'(4*g+2), 4'(4*g+1), 4'(4*g)}, 4'h0, 4'h0, 1'b0);
            do_reset();
            step(4);
            for (int s = 0; s < 4; s++) begin
                tests_run++;
                if (bus4.DIGIT !== sel4[s] || bus4.DISPLAY !== codes[4*g+s]) begin
                    tests_failed++;
                    $display("FAIL code_%0h: DIGIT=%h DISPLAY=%h, want %h %h",
                             4*g+s, bus4.DIGIT, bus4.DISPLAY, sel4[s], codes[4*g+s]);
                end
                step(4);
            end
        end
    endtask

    task automatic test_lz();
        logic [7:0] exp_a [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
        logic [7:0] exp_b [4] = '{8'h40, 8'hFF, 8'hFF, 8'hFF};
        set4(16'h0050, 4'b1000, 4'h0, 1'b1);
        do_reset();
        step(4);
        for (int s = 0; s < 4; s++) begin
            tests_run++;
            if (bus4.DIGIT !== sel4[s] || bus4.DISPLAY !== exp_a[s]) begin
                tests_failed++;
                $display("FAIL lz_0050 s%0d: DIGIT=%h DISPLAY=%h, want %h %h",
                         s, bus4.DIGIT, bus4.DISPLAY, sel4[s], exp_a[s]);
            end
            step(4);
        end
        set4(16'h0000, 4'b1111, 4'h0, 1'b1);
        do_reset();
        step(4);
        for (int s = 0; s < 4; s++) begin
            tests_run++;
            if (bus4.DIGIT !== sel4[s] || bus4.DISPLAY !== exp_b[s]) begin
                tests_failed++;
                $display("FAIL lz_0000 s%0d: DIGIT=%h DISPLAY=%h, want %h %h",
                         s, bus4.DIGIT, bus4.DISPLAY, sel4[s], exp_b[s]);
            end
            step(4);
        end
    endtask

    task automatic test_blink();
        logic [7:0] exp_s0 [6] = '{8'h99, 8'h99, 8'hFF, 8'hFF, 8'h99, 8'h99};
        set4(16'h1234, 4'b0010, 4'b0001, 1'b0);
        do_reset();
        step(4);
        for (int f = 0; f < 6; f++) begin
            tests_run++;
            if (bus4.DIGIT !== 4'hE || bus4.DISPLAY !== exp_s0[f]) begin
                tests_failed++;
                $display("FAIL blink_s0 f%0d: DIGIT=%h DISPLAY=%h, want E %h",
                         f, bus4.DIGIT, bus4.DISPLAY, exp_s0[f]);
            end
            step(4);
            tests_run++;
            if (bus4.DIGIT !== 4'hD || bus4.DISPLAY !== 8'h30) begin
                tests_failed++;
                $display("FAIL dp_s1 f%0d: DIGIT=%h DISPLAY=%h, want D 30",
                         f, bus4.DIGIT, bus4.DISPLAY);
            end
            step(12);
        end
    endtask

    task automatic test_midframe();
        logic [7:0] exp_n [4] = '{8'h80, 8'hF8, 8'h82, 8'h92};
        set4(16'h1234, 4'h0, 4'h0, 1'b0);
        do_reset();
        step(8);
        bus4.digits = 16'h5678;
        bus4.dp_en  = 4'hF;
        step(4);
        tests_run++;
        if (bus4.DIGIT !== 4'hB || bus4.DISPLAY !== 8'hA4) begin
            tests_failed++;
            $display("FAIL mid_s2: DIGIT=%h DISPLAY=%h, want B A4", bus4.DIGIT, bus4.DISPLAY);
        end
        step(4);
        tests_run++;
        if (bus4.DIGIT !== 4'h7 || bus4.DISPLAY !== 8'hF9) begin
            tests_failed++;
            $display("FAIL mid_s3: DIGIT=%h DISPLAY=%h, want 7 F9", bus4.DIGIT, bus4.DISPLAY);
        end
        bus4.dp_en = 4'h0;
        step(4);
        for (int s = 0; s < 4; s++) begin
            tests_run++;
            if (bus4.DIGIT !== sel4[s] || bus4.DISPLAY !== exp_n[s]) begin
                tests_failed++;
                $display("FAIL next_frame s%0d: DIGIT=%h DISPLAY=%h, want %h %h",
                         s, bus4.DIGIT, bus4.DISPLAY, sel4[s], exp_n[s]);
            end
            step(4);
        end
    endtask

    task automatic test_async_reset();
        set4(16'h1234, 4'h0, 4'h0, 1'b0);
        do_reset();
        step(9);
        tests_run++;
        if (bus4.DIGIT !== 4'hD) begin
            tests_failed++;
            $display("FAIL pre_reset: DIGIT=%h, want D", bus4.DIGIT);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus4.DIGIT !== 4'hF || bus4.DISPLAY !== 8'hFF) begin
            tests_failed++;
            $display("FAIL async_dark: DIGIT=%h DISPLAY=%h, want F FF", bus4.DIGIT, bus4.DISPLAY);
        end
        rst_n = 1'b1;
        @(negedge clk);
        step(2);
        tests_run++;
        if (bus4.DIGIT !== 4'hF) begin
            tests_failed++;
            $display("FAIL post_reset_dark: DIGIT=%h, want F", bus4.DIGIT);
        end
        step(1);
        tests_run++;
        if (bus4.DIGIT !== 4'hE || bus4.DISPLAY !== 8'h99 || bus4.frame_tick !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_first: DIGIT=%h DISPLAY=%h tick=%b, want E 99 1",
                     bus4.DIGIT, bus4.DISPLAY, bus4.frame_tick);
        end
    endtask

    task automatic test_enable();
        set4(16'h1234, 4'h0, 4'b0001, 1'b0);
        do_reset();
        step(36);
        tests_run++;
        if (bus4.DIGIT !== 4'hE || bus4.DISPLAY !== 8'hFF) begin
            tests_failed++;
            $display("FAIL en_off_phase: DIGIT=%h DISPLAY=%h, want E FF", bus4.DIGIT, bus4.DISPLAY);
        end
        step(4);
        bus4.enable = 1'b0;
        step(1);
        tests_run++;
        if (bus4.DIGIT !== 4'hF || bus4.DISPLAY !== 8'hFF || bus4.frame_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_dark: DIGIT=%h DISPLAY=%h tick=%b, want F FF 0",
                     bus4.DIGIT, bus4.DISPLAY, bus4.frame_tick);
        end
        step(2);
        bus4.enable = 1'b1;
        step(3);
        tests_run++;
        if (bus4.DIGIT !== 4'hF) begin
            tests_failed++;
            $display("FAIL reen_dark: DIGIT=%h, want F", bus4.DIGIT);
        end
        step(1);
        tests_run++;
        if (bus4.DIGIT !== 4'hE || bus4.DISPLAY !== 8'hFF || bus4.frame_tick !== 1'b1) begin
            tests_failed++;
            $display("FAIL reen_first: DIGIT=%h DISPLAY=%h tick=%b, want E FF 1",
                     bus4.DIGIT, bus4.DISPLAY, bus4.frame_tick);
        end
        step(16);
        tests_run++;
        if (bus4.DIGIT !== 4'hE || bus4.DISPLAY !== 8'h99) begin
            tests_failed++;
            $display("FAIL reen_toggle: DIGIT=%h DISPLAY=%h, want E 99", bus4.DIGIT, bus4.DISPLAY);
        end
        bus4.blink_en = 4'h0;
    endtask

    task automatic test_single_digit();
        logic [7:0] exp_d [3] = '{8'hF8, 8'hFF, 8'hF8};
        bus1.digits   = 4'h7;
        bus1.dp_en    = 1'b0;
        bus1.blink_en = 1'b1;
        bus1.blank_lz = 1'b1;
        do_reset();
        step(2);
        for (int f = 0; f < 3; f++) begin
            tests_run++;
            if (bus1.DIGIT !== 1'b0 || bus1.DISPLAY !== exp_d[f] || bus1.frame_tick !== 1'b1) begin
                tests_failed++;
                $display("FAIL single f%0d: DIGIT=%b DISPLAY=%h tick=%b, want 0 %h 1",
                         f, bus1.DIGIT, bus1.DISPLAY, bus1.frame_tick, exp_d[f]);
            end
            step(1);
            tests_run++;
            if (bus1.frame_tick !== 1'b0 || bus1.DISPLAY !== exp_d[f]) begin
                tests_failed++;
                $display("FAIL single_hold f%0d: DISPLAY=%h tick=%b, want %h 0",
                         f, bus1.DISPLAY, bus1.frame_tick, exp_d[f]);
            end
            step(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        bus4.enable = 1'b1;
        set4(16'h0000, 4'h0, 4'h0, 1'b0);
        bus1.enable   = 1'b1;
        bus1.digits   = 4'h0;
        bus1.dp_en    = 1'b0;
        bus1.blink_en = 1'b0;
        bus1.blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_codes();
        test_lz();
        test_blink();
        test_midframe();
        test_async_reset();
        test_enable();
        test_single_digit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
